// File: rtl/disp_scan_4digit_pkg.sv
// disp_scan_4digit_pkg: shared anode/segment constants and active-low hex digit table
package disp_scan_4digit_pkg;
    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [3:0] AN_OFF = 4'hF;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [16*7-1:0] HEX7_TAB = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };
endpackage

// File: rtl/disp_scan_4digit_hex_to_seg7.sv
// hex_to_seg7: combinational 4-bit to active-low 7-segment {g..a} decoder
module hex_to_seg7
    import disp_scan_4digit_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);
    assign seg = HEX7_TAB[7*nib +: 7];
endmodule

// File: rtl/disp_scan_4digit.sv
// disp_scan_4digit: frame-latched 4-digit multiplexed 7-segment driver with guard gap and zero blanking
module disp_scan_4digit
    import disp_scan_4digit_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int GUARD = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    output logic [3:0]  an,
    output logic [7:0]  seg,
    output logic        frame_tick
);
    localparam int PW = $clog2(SCAN_DIV);
    logic [PW-1:0] pre_q, pre_d;
    logic [1:0] idx_q, idx_d;
    logic [15:0] val_q, val_d;
    logic [3:0] dp_q, dp_d, an_q, an_d;
    logic [7:0] seg_q, seg_d;
    logic tick_q, tick_d, wrap, frame_end, dark, blank;
    logic [6:0] hex;
    hex_to_seg7 u_dec (.nib(val_q[4*idx_q +: 4]), .seg(hex));
    always_comb begin
        wrap = en && pre_q == PW'(SCAN_DIV - 1);
        frame_end = wrap && idx_q == 2'd3;
        pre_d = !en ? pre_q : wrap ? '0 : pre_q + 1'b1;
        idx_d = wrap ? idx_q + 2'd1 : idx_q;
        val_d = frame_end ? value : val_q;
        dp_d = frame_end ? dp_in : dp_q;
        tick_d = frame_end;
        dark = !en || 32'(pre_q) < GUARD;
        blank = blank_lz && idx_q != 2'd0 && (val_q >> (4*idx_q)) == 16'd0;
        an_d = dark ? AN_OFF : ~(4'b1 << idx_q);
        seg_d = dark ? SEG_OFF : {~dp_q[idx_q], blank ? SEG_BLANK : hex};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q <= '0;
            idx_q <= '0;
            val_q <= '0;
            dp_q <= '0;
            an_q <= AN_OFF;
            seg_q <= SEG_OFF;
            tick_q <= 1'b0;
        end else begin
            pre_q <= pre_d;
            idx_q <= idx_d;
            val_q <= val_d;
            dp_q <= dp_d;
            an_q <= an_d;
            seg_q <= seg_d;
            tick_q <= tick_d;
        end
    end
    assign an = an_q;
    assign seg = seg_q;
    assign frame_tick = tick_q;
endmodule
